// File: rtl/pll_mgmt_pkg.sv
// pll_mgmt_pkg
//   Shared definitions for the PLL reconfiguration management responder:
//   register addresses, FSM state encoding, counter-word layout and the
//   C0 divide decoder.
package pll_mgmt_pkg;

    localparam logic [5:0] ADDR_MODE   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_START  = 6'd2;
    localparam logic [5:0] ADDR_N      = 6'd3;
    localparam logic [5:0] ADDR_M      = 6'd4;
    localparam logic [5:0] ADDR_C0     = 6'd5;
    localparam logic [5:0] ADDR_MFRAC  = 6'd7;

    // Width of the busy/relock down-counter.
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        BUSY,
        APPLY,
        RELOCK
    } state_t;

    // Layout of an Altera-style counter word.
    typedef struct packed {
        logic [13:0] rsvd;
        logic        odd;
        logic        bypass;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } cnt_word_t;

    // Effective divide ratio: bypass gives 1, otherwise high+low count.
    // The sum is kept at 9 bits so 255+255 does not wrap.
    function automatic logic [8:0] cnt_div(input cnt_word_t w);
        if (w.bypass) begin
            return 9'd1;
        end
        return {1'b0, w.hi} + {1'b0, w.lo};
    endfunction

endpackage

// File: rtl/pll_mgmt_timer.sv
// pll_mgmt_timer
//   Loadable down-counter with a zero flag. Loading wins over counting;
//   the count stops at zero.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load load_val this cycle
//   load_val    value to load
//   zero        counter currently at zero
module pll_mgmt_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: assigning a default before any branch keeps always_comb free of inferred latches.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pll_mgmt_responder.sv
// pll_mgmt_responder
//   Avalon-MM responder standing in for the PLL reconfiguration management
//   port. Holds shadow N/M/C0/M-frac words, copies them to the active set
//   after a BUSY_CYCLES window, then drops locked for LOCK_CYCLES.
//   Optional build macro: PLL_MGMT_READBACK_EN makes addresses 3/4/5/7
//   read back the shadow words (otherwise they read 0).
// Ports:
//   mgmt_clk, mgmt_reset_n        clock, asynchronous active-low reset
//   mgmt_write/read/address/writedata   Avalon-MM request
//   mgmt_readdata, mgmt_waitrequest     Avalon-MM response
//   act_n/m/c0/mfrac              active counter words
//   c0_div                        decoded C0 divide (registered from act_c0)
//   cfg_applied                   one-cycle pulse as active words update
//   locked                        lock indication
module pll_mgmt_responder
    import pll_mgmt_pkg::*;
#(
    parameter int BUSY_CYCLES = 64,
    parameter int LOCK_CYCLES = 32
) (
    input  logic        mgmt_clk,
    input  logic        mgmt_reset_n,
    input  logic        mgmt_write,
    input  logic        mgmt_read,
    input  logic [5:0]  mgmt_address,
    input  logic [31:0] mgmt_writedata,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_waitrequest,
    output logic [31:0] act_n,
    output logic [31:0] act_m,
    output logic [31:0] act_c0,
    output logic [31:0] act_mfrac,
    output logic [8:0]  c0_div,
    output logic        cfg_applied,
    output logic        locked
);

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic        done_q, done_d;
    logic        rd_ack_q, rd_ack_d;
    logic        locked_q, locked_d;
    logic        cfg_applied_q, cfg_applied_d;
    logic [8:0]  c0_div_q, c0_div_d;
    logic [31:0] readdata_q, readdata_d;
    logic [31:0] sh_n_q, sh_m_q, sh_c0_q, sh_mfrac_q;
    logic [31:0] sh_n_d, sh_m_d, sh_c0_d, sh_mfrac_d;
    logic [31:0] act_n_q, act_m_q, act_c0_q, act_mfrac_q;
    logic [31:0] act_n_d, act_m_d, act_c0_d, act_mfrac_d;

    logic        in_busy, wait_req, wr_en, start_en, rd_capture, timer_zero;
    logic        timer_load;
    logic [CNT_W-1:0] timer_val;
    logic [31:0] rd_word;

    assign in_busy = (state_q == BUSY) || (state_q == APPLY) || (state_q == RELOCK);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_en) state_d = BUSY;
                     else if (rd_capture) state_d = RD;
            RD:      state_d = start_en ? BUSY : IDLE;
            BUSY:    if (timer_zero) state_d = APPLY;
            APPLY:   state_d = RELOCK;
            RELOCK:  if (timer_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Waitrequest mode stalls everything while busy. Otherwise a write never
    // waits, and a read waits one cycle while its data is registered. In IDLE
    // the RD state is that second cycle; while busy (polling) rd_ack_q is.
    always_comb begin
        wait_req   = 1'b0;
        rd_capture = 1'b0;
        if (in_busy && !mode_q) begin
            wait_req = mgmt_write || mgmt_read;
        end else if (state_q != RD) begin
            wait_req   = mgmt_read && !mgmt_write && !rd_ack_q;
            rd_capture = wait_req;
        end
    end

    assign wr_en      = mgmt_write && !wait_req;
    // A start write is only honoured when no reconfiguration is in flight.
    assign start_en   = wr_en && (mgmt_address == ADDR_START) && !in_busy;
    assign timer_load = start_en || (state_q == APPLY);
    assign timer_val  = (state_q == APPLY) ? CNT_W'(LOCK_CYCLES - 1)
                                           : CNT_W'(BUSY_CYCLES - 1);

    pll_mgmt_timer #(.W(CNT_W)) u_timer (
        .clk      (mgmt_clk),
        .rst_n    (mgmt_reset_n),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // ---------------- read mux ----------------
    always_comb begin
        rd_word = '0;
        case (mgmt_address)
            ADDR_MODE:   rd_word = {31'd0, mode_q};
            ADDR_STATUS: rd_word = {31'd0, done_q};
`ifdef PLL_MGMT_READBACK_EN
            ADDR_N:      rd_word = sh_n_q;
            ADDR_M:      rd_word = sh_m_q;
            ADDR_C0:     rd_word = sh_c0_q;
            ADDR_MFRAC:  rd_word = sh_mfrac_q;
`endif
            default:     rd_word = '0;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        mode_d        = mode_q;
        done_d        = done_q;
        locked_d      = locked_q;
        readdata_d    = readdata_q;
        sh_n_d        = sh_n_q;
        sh_m_d        = sh_m_q;
        sh_c0_d       = sh_c0_q;
        sh_mfrac_d    = sh_mfrac_q;
        act_n_d       = act_n_q;
        act_m_d       = act_m_q;
        act_c0_d      = act_c0_q;
        act_mfrac_d   = act_mfrac_q;
        rd_ack_d      = rd_capture && in_busy;
        cfg_applied_d = (state_q == APPLY);
        c0_div_d      = cnt_div(cnt_word_t'(act_c0_q));

        if (rd_capture) readdata_d = rd_word;

        if (wr_en) begin
            case (mgmt_address)
                ADDR_MODE:  mode_d     = mgmt_writedata[0];
                ADDR_N:     sh_n_d     = mgmt_writedata;
                ADDR_M:     sh_m_d     = mgmt_writedata;
                ADDR_C0:    sh_c0_d    = mgmt_writedata;
                ADDR_MFRAC: sh_mfrac_d = mgmt_writedata;
                default:    ;
            endcase
        end
        if (start_en) done_d = 1'b0;

        if (state_q == APPLY) begin
            act_n_d     = sh_n_q;
            act_m_d     = sh_m_q;
            act_c0_d    = sh_c0_q;
            act_mfrac_d = sh_mfrac_q;
            locked_d    = 1'b0;
        end
        if ((state_q == RELOCK) && timer_zero) begin
            locked_d = 1'b1;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            mode_q        <= 1'b0;
            done_q        <= 1'b1;
            rd_ack_q      <= 1'b0;
            locked_q      <= 1'b1;
            cfg_applied_q <= 1'b0;
            c0_div_q      <= '0;
            readdata_q    <= '0;
            sh_n_q        <= '0;
            sh_m_q        <= '0;
            sh_c0_q       <= '0;
            sh_mfrac_q    <= '0;
            act_n_q       <= '0;
            act_m_q       <= '0;
            act_c0_q      <= '0;
            act_mfrac_q   <= '0;
        end else begin
            mode_q        <= mode_d;
            done_q        <= done_d;
            rd_ack_q      <= rd_ack_d;
            locked_q      <= locked_d;
            cfg_applied_q <= cfg_applied_d;
            c0_div_q      <= c0_div_d;
            readdata_q    <= readdata_d;
            sh_n_q        <= sh_n_d;
            sh_m_q        <= sh_m_d;
            sh_c0_q       <= sh_c0_d;
            sh_mfrac_q    <= sh_mfrac_d;
            act_n_q       <= act_n_d;
            act_m_q       <= act_m_d;
            act_c0_q      <= act_c0_d;
            act_mfrac_q   <= act_mfrac_d;
        end
    end

    assign mgmt_readdata    = readdata_q;
    assign mgmt_waitrequest = wait_req;
    assign act_n            = act_n_q;
    assign act_m            = act_m_q;
    assign act_c0           = act_c0_q;
    assign act_mfrac        = act_mfrac_q;
    assign c0_div           = c0_div_q;
    assign cfg_applied      = cfg_applied_q;
    assign locked           = locked_q;

endmodule

// File: tb/tb_pll_mgmt_responder.sv
// tb_pll_mgmt_responder
//   Directed bench for pll_mgmt_responder: reset state, NTSC/PAL sequences,
//   waitrequest-mode stall length, polling mode, bypass decode and reset
//   during BUSY.
module tb_pll_mgmt_responder;

    logic        mgmt_clk = 1'b0;
    logic        mgmt_reset_n = 1'b0;
    logic        mgmt_write = 1'b0;
    logic        mgmt_read = 1'b0;
    logic [5:0]  mgmt_address = '0;
    logic [31:0] mgmt_writedata = '0;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic [31:0] act_n, act_m, act_c0, act_mfrac;
    logic [8:0]  c0_div;
    logic        cfg_applied;
    logic        locked;

    int n_checks = 0;
    int n_errors = 0;
    int applied_cnt = 0;

    pll_mgmt_responder dut (
        .mgmt_clk         (mgmt_clk),
        .mgmt_reset_n     (mgmt_reset_n),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .act_n            (act_n),
        .act_m            (act_m),
        .act_c0           (act_c0),
        .act_mfrac        (act_mfrac),
        .c0_div           (c0_div),
        .cfg_applied      (cfg_applied),
        .locked           (locked)
    );

    always #5 mgmt_clk = ~mgmt_clk;

    // Count cfg_applied pulses, sampled away from the active edge.
    always @(negedge mgmt_clk) begin
        if (cfg_applied) applied_cnt <= applied_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge mgmt_clk);
        #2;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, output int stalls);
        mgmt_address   = a;
        mgmt_writedata = d;
        mgmt_write     = 1'b1;
        stalls = 0;
        #1;
        while (mgmt_waitrequest && stalls < 300) begin
            step();
            stalls++;
        end
        @(posedge mgmt_clk);
        #1;
        mgmt_write = 1'b0;
        if (stalls >= 300) check("wr_timeout", 32'(stalls), 32'd0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        int s;
        bus_write(a, d, s);
        check("wr_nowait", 32'(s), 32'd0);
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d, output int stalls);
        mgmt_address = a;
        mgmt_read    = 1'b1;
        stalls = 0;
        #1;
        while (mgmt_waitrequest && stalls < 300) begin
            step();
            stalls++;
        end
        d = mgmt_readdata;
        @(posedge mgmt_clk);
        #1;
        mgmt_read = 1'b0;
        if (stalls >= 300) check("rd_timeout", 32'(stalls), 32'd0);
    endtask

    // Cycles from the start-write edge until cfg_applied is seen high.
    task automatic wait_applied(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!cfg_applied && n < 300);
    endtask

    // Called one cycle after cfg_applied; the two cycles so far count as low.
    task automatic wait_relock(output int low);
        low = 2;
        while (!locked && low < 300) begin
            step();
            if (!locked) low++;
        end
    endtask

    initial begin
        logic [31:0] rd, exp_rb;
        int s, n, low, zeros, base;
        bit  found;

        // ---- 1: reset state ----
        repeat (3) @(posedge mgmt_clk);
        #1;
        mgmt_reset_n = 1'b1;
        #1;
        check("rst_waitreq", {31'd0, mgmt_waitrequest}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd1);
        check("rst_act_n", act_n, 32'd0);
        check("rst_act_c0", act_c0, 32'd0);
        check("rst_cfg_applied", {31'd0, cfg_applied}, 32'd0);
        check("rst_c0_div", {23'd0, c0_div}, 32'd0);
        check("rst_readdata", mgmt_readdata, 32'd0);
        bus_read(6'd1, rd, s);
        check("rst_status_wait", 32'(s), 32'd1);
        check("rst_status", rd, 32'd1);
        bus_read(6'd0, rd, s);
        check("rst_mode", rd, 32'd0);
        bus_read(6'd6, rd, s);
        check("unmapped_read", rd, 32'd0);

        // ---- 2: NTSC sequence ----
        wr(6'd0, 32'd0);
        wr(6'd3, 32'h0001_0000);
        wr(6'd4, 32'h0000_0404);
        wr(6'd5, 32'h0000_0505);
        wr(6'd7, 32'h9745_BF27);
        wr(6'd6, 32'hDEAD_BEEF);
        wr(6'd2, 32'd0);
        wait_applied(n);
        check("ntsc_latency", 32'(n), 32'd65);
        check("ntsc_act_n", act_n, 32'h0001_0000);
        check("ntsc_act_m", act_m, 32'h0000_0404);
        check("ntsc_act_c0", act_c0, 32'h0000_0505);
        check("ntsc_act_mfrac", act_mfrac, 32'h9745_BF27);
        check("ntsc_locked_low", {31'd0, locked}, 32'd0);
        step();
        check("ntsc_pulse_width", {31'd0, cfg_applied}, 32'd0);
        check("ntsc_c0_div", {23'd0, c0_div}, 32'd10);
        wait_relock(low);
        check("ntsc_lock_low_cycles", 32'(low), 32'd32);
        bus_read(6'd1, rd, s);
        check("ntsc_status_done", rd, 32'd1);
`ifdef PLL_MGMT_READBACK_EN
        exp_rb = 32'h0000_0505;
`else
        exp_rb = 32'd0;
`endif
        bus_read(6'd5, rd, s);
        check("readback_c0_wait", 32'(s), 32'd1);
        check("readback_c0", rd, exp_rb);

        // ---- 3: PAL sequence (bit17 set, bit16 clear: no bypass, 5+4) ----
        wr(6'd5, 32'h0002_0504);
        wr(6'd7, 32'hA3D7_09E8);
        wr(6'd2, 32'd0);
        wait_applied(n);
        check("pal_latency", 32'(n), 32'd65);
        check("pal_act_mfrac", act_mfrac, 32'hA3D7_09E8);
        check("pal_act_c0", act_c0, 32'h0002_0504);
        check("pal_act_n_kept", act_n, 32'h0001_0000);
        step();
        check("pal_c0_div", {23'd0, c0_div}, 32'd9);
        wait_relock(low);
        check("pal_lock_low_cycles", 32'(low), 32'd32);

        // ---- 4: waitrequest mode stall ----
        wr(6'd4, 32'h0000_0606);
        wr(6'd2, 32'd0);
        base = applied_cnt;
        bus_write(6'd4, 32'h0BAD_F00D, s);
        check("wreq_stall_cycles", 32'(s), 32'd97);
        check("wreq_act_m", act_m, 32'h0000_0606);
        check("wreq_locked", {31'd0, locked}, 32'd1);
        check("wreq_one_pulse", 32'(applied_cnt - base), 32'd1);
`ifdef PLL_MGMT_READBACK_EN
        exp_rb = 32'h0BAD_F00D;
`else
        exp_rb = 32'd0;
`endif
        bus_read(6'd4, rd, s);
        check("readback_m", rd, exp_rb);

        // ---- 5: polling mode ----
        wr(6'd0, 32'd1);
        wr(6'd5, 32'h0000_FFFF);
        base = applied_cnt;
        wr(6'd2, 32'd0);
        bus_read(6'd1, rd, s);
        check("poll_status_busy", rd, 32'd0);
        check("poll_read_wait", 32'(s), 32'd1);
        bus_read(6'd0, rd, s);
        check("poll_mode_read", rd, 32'd1);
        wr(6'd2, 32'd0);
        wr(6'd7, 32'h1234_5678);
        zeros = 0;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            bus_read(6'd1, rd, s);
            if (rd == 32'd1) found = 1'b1;
            else zeros++;
        end
        check("poll_done_seen", {31'd0, found}, 32'd1);
        check("poll_zero_polls_ge40", {31'd0, zeros >= 40}, 32'd1);
        check("poll_one_pulse", 32'(applied_cnt - base), 32'd1);
        check("poll_act_mfrac", act_mfrac, 32'h1234_5678);
        check("poll_c0_div_510", {23'd0, c0_div}, 32'd510);
        repeat (150) step();
        check("poll_second_start_ignored", 32'(applied_cnt - base), 32'd1);
        bus_read(6'd1, rd, s);
        check("poll_status_still_done", rd, 32'd1);

        // ---- bypass decode ----
        wr(6'd5, 32'h0001_0505);
        wr(6'd2, 32'd0);
        wait_applied(n);
        step();
        check("bypass_c0_div", {23'd0, c0_div}, 32'd1);
        wait_relock(low);

        // ---- 6: reset during BUSY ----
        wr(6'd0, 32'd0);
        wr(6'd2, 32'd0);
        repeat (10) step();
        base = applied_cnt;
        mgmt_address = 6'd6;
        mgmt_write   = 1'b1;
        #1;
        check("busy_waitreq_before_rst", {31'd0, mgmt_waitrequest}, 32'd1);
        mgmt_reset_n = 1'b0;
        #1;
        check("rst_mid_waitreq", {31'd0, mgmt_waitrequest}, 32'd0);
        check("rst_mid_locked", {31'd0, locked}, 32'd1);
        check("rst_mid_act_c0", act_c0, 32'd0);
        check("rst_mid_act_mfrac", act_mfrac, 32'd0);
        check("rst_mid_c0_div", {23'd0, c0_div}, 32'd0);
        mgmt_write = 1'b0;
        repeat (2) step();
        #1;
        mgmt_reset_n = 1'b1;
        repeat (120) step();
        check("rst_mid_no_pulse", 32'(applied_cnt - base), 32'd0);
        check("rst_mid_act_n_after", act_n, 32'd0);
        bus_read(6'd1, rd, s);
        check("rst_mid_status", rd, 32'd1);
        bus_read(6'd0, rd, s);
        check("rst_mid_mode", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
